// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, divider FSM states and op decode helper
//
// Contents:
//   ALUCTR_W                      width of the alu_ctr op code
//   ALU_DIV/DIVU/REM/REMU         divide op codes, shared with the ALU decode
//   div_state_t                   divider sequencer states
//   is_div_op()                   true for the four RV32M divide op codes
package alu_pkg;

  localparam int ALUCTR_W = 5;

  localparam logic [ALUCTR_W-1:0] ALU_DIV  = 5'b01110;
  localparam logic [ALUCTR_W-1:0] ALU_DIVU = 5'b01111;
  localparam logic [ALUCTR_W-1:0] ALU_REM  = 5'b10000;
  localparam logic [ALUCTR_W-1:0] ALU_REMU = 5'b10001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  function automatic logic is_div_op(input logic [ALUCTR_W-1:0] alu_ctr);
    return (alu_ctr == ALU_DIV) || (alu_ctr == ALU_DIVU) ||
           (alu_ctr == ALU_REM) || (alu_ctr == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring divide step
//
// Ports:
//   rem       in   DATA_WIDTH  partial remainder (always < divisor)
//   quo       in   DATA_WIDTH  dividend bits still to shift in / quotient bits so far
//   divisor   in   DATA_WIDTH  unsigned divisor magnitude
//   rem_next  out  DATA_WIDTH  partial remainder after this step
//   quo_next  out  DATA_WIDTH  quotient register after this step
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  // Shifted remainder needs one extra bit so the compare cannot overflow.
  logic [DATA_WIDTH:0] rem_sh;
  logic                ge;

  always_comb begin
    rem_sh   = {rem, quo[DATA_WIDTH-1]};
    ge       = (rem_sh >= {1'b0, divisor});
    quo_next = {quo[DATA_WIDTH-2:0], ge};
    // When ge, the true difference is below divisor, so the low bits are exact.
    rem_next = ge ? (rem_sh[DATA_WIDTH-1:0] - divisor) : rem_sh[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle RV32M DIV/DIVU/REM/REMU sequencer
//
// Ports:
//   clk      in   1             clock, all state on the rising edge
//   rst      in   1             synchronous active-high reset
//   start    in   1             request, sampled only in IDLE
//   flush    in   1             synchronous abort, drops any op in flight
//   alu_ctr  in   ALUCTR_WIDTH  op code (divide codes from alu_pkg)
//   alu_op1  in   DATA_WIDTH    dividend
//   alu_op2  in   DATA_WIDTH    divisor
//   busy     out  1             high while iterating (CALC)
//   done     out  1             one-cycle result-valid pulse (DONE)
//   result   out  DATA_WIDTH    registered result, held until the next op completes
module div_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALUCTR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    flush,
  input  logic [ALUCTR_WIDTH-1:0] alu_ctr,
  input  logic [DATA_WIDTH-1:0]   alu_op1,
  input  logic [DATA_WIDTH-1:0]   alu_op2,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result
);

  localparam int                    CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO     = '0;
  localparam logic [DATA_WIDTH-1:0] ONES     = '1;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  op_rem_q, op_rem_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic [DATA_WIDTH-1:0] step_rem, step_quo;

  // Operand decode on the live inputs; only meaningful in the accept cycle.
  logic                  signed_op, is_rem_op, s1, s2, ovf_case;
  logic [DATA_WIDTH-1:0] abs1, abs2;

  assign signed_op = (alu_ctr == ALU_DIV) || (alu_ctr == ALU_REM);
  assign is_rem_op = (alu_ctr == ALU_REM) || (alu_ctr == ALU_REMU);
  assign s1        = signed_op & alu_op1[DATA_WIDTH-1];
  assign s2        = signed_op & alu_op2[DATA_WIDTH-1];
  assign abs1      = s1 ? (ZERO - alu_op1) : alu_op1;
  assign abs2      = s2 ? (ZERO - alu_op2) : alu_op2;
  assign ovf_case  = signed_op && (alu_op1 == MIN_NEG) && (alu_op2 == ONES);

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    op_rem_d = op_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start && is_div_op(alu_ctr)) begin
          op_rem_d = is_rem_op;
          if (alu_op2 == ZERO) begin
            result_d = is_rem_op ? alu_op1 : ONES;
            state_d  = DONE;
          end else if (ovf_case) begin
            result_d = is_rem_op ? ZERO : MIN_NEG;
            state_d  = DONE;
          end else begin
            rem_d   = ZERO;
            quo_d   = abs1;
            dvs_d   = abs2;
            q_neg_d = s1 ^ s2;
            r_neg_d = s1;
            cnt_d   = CNT_INIT;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Sign fix-up happens on the last step so result is ready with done.
          if (op_rem_q) result_d = r_neg_q ? (ZERO - step_rem) : step_rem;
          else          result_d = q_neg_q ? (ZERO - step_quo) : step_quo;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over any accept or completion in the same cycle.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      op_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      op_rem_q <= op_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
